// File: rtl/board_pkg.sv
// Shared constants and FSM state type for the board-state RAM arbiter.
package board_pkg;

  localparam int unsigned BOARD_DIM       = 10;
  localparam int unsigned CELLS_PER_BOARD = 100;
  localparam int unsigned MEM_DEPTH       = 200;
  localparam int unsigned ADDR_W          = 8;

  localparam logic [1:0] CELL_WATER = 2'd0;
  localparam logic [1:0] CELL_SHIP  = 2'd1;
  localparam logic [1:0] CELL_HIT   = 2'd2;
  localparam logic [1:0] CELL_MISS  = 2'd3;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } arb_state_t;

endpackage

// File: rtl/board_addr_calc.sv
// Combinational (board, row, col) to RAM address mapping with range check.
module board_addr_calc #(
  parameter int unsigned BOARD_DIM = 10,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic              board,
  input  logic [3:0]        row,
  input  logic [3:0]        col,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);
  import board_pkg::*;

  logic [ADDR_W-1:0] row_x;
  logic [ADDR_W-1:0] col_x;
  logic [ADDR_W-1:0] base;

  always_comb begin
    row_x    = ADDR_W'(row);
    col_x    = ADDR_W'(col);
    base     = board ? ADDR_W'(CELLS_PER_BOARD) : '0;
    // ROW*10 as shift-add keeps this a pure adder tree
    addr     = base + (row_x << 3) + (row_x << 1) + col_x;
    in_range = (32'(row) < BOARD_DIM) && (32'(col) < BOARD_DIM);
  end

endmodule

// File: rtl/board_mem_arbiter.sv
// Single-port board RAM scheduler: video reads > clear sweep > round-robin writers.
module board_mem_arbiter #(
  parameter int unsigned BOARD_DIM = 10,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic              CLOCK_50,
  input  logic              Reset,
  input  logic              VID_REQ,
  input  logic              VID_BOARD,
  input  logic [3:0]        VID_ROW,
  input  logic [3:0]        VID_COL,
  output logic [1:0]        VID_DATA,
  output logic              VID_VALID,
  input  logic              WR0_REQ,
  input  logic              WR0_BOARD,
  input  logic [3:0]        WR0_ROW,
  input  logic [3:0]        WR0_COL,
  input  logic [1:0]        WR0_DATA,
  output logic              WR0_ACK,
  input  logic              WR1_REQ,
  input  logic              WR1_BOARD,
  input  logic [3:0]        WR1_ROW,
  input  logic [3:0]        WR1_COL,
  input  logic [1:0]        WR1_DATA,
  output logic              WR1_ACK,
  output logic              WR_ERR,
  input  logic              CLR_START,
  output logic              CLR_BUSY,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_WE,
  output logic [1:0]        MEM_WDATA,
  input  logic [1:0]        MEM_RDATA
);
  import board_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(2 * BOARD_DIM * BOARD_DIM - 1);

  logic [ADDR_W-1:0] vid_addr, wr0_addr, wr1_addr;
  logic              vid_inr, wr0_inr, wr1_inr;

  board_addr_calc #(.BOARD_DIM(BOARD_DIM), .ADDR_W(ADDR_W)) u_vid_addr (
    .board(VID_BOARD), .row(VID_ROW), .col(VID_COL), .addr(vid_addr), .in_range(vid_inr)
  );
  board_addr_calc #(.BOARD_DIM(BOARD_DIM), .ADDR_W(ADDR_W)) u_wr0_addr (
    .board(WR0_BOARD), .row(WR0_ROW), .col(WR0_COL), .addr(wr0_addr), .in_range(wr0_inr)
  );
  board_addr_calc #(.BOARD_DIM(BOARD_DIM), .ADDR_W(ADDR_W)) u_wr1_addr (
    .board(WR1_BOARD), .row(WR1_ROW), .col(WR1_COL), .addr(wr1_addr), .in_range(wr1_inr)
  );

  arb_state_t        state, state_next;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_next;
  logic              last_wr, last_wr_next;
  logic              vid_gnt, clr_gnt, wr0_gnt, wr1_gnt;
  logic              wr0_elig, wr1_elig;
  logic              vid_pend, vid_oor;

  // Grants are gated by Reset so the RAM port stays quiet while reset is held.
  always_comb begin
    vid_gnt   = 1'b0;
    clr_gnt   = 1'b0;
    wr0_gnt   = 1'b0;
    wr1_gnt   = 1'b0;
    wr0_elig  = WR0_REQ && !WR0_ACK;
    wr1_elig  = WR1_REQ && !WR1_ACK;
    MEM_ADDR  = '0;
    MEM_WE    = 1'b0;
    MEM_WDATA = CELL_WATER;
    last_wr_next = last_wr;

    if (Reset) begin
      if (VID_REQ) begin
        vid_gnt = 1'b1;
      end else if (state == S_CLEAR) begin
        clr_gnt = 1'b1;
      end else if (wr0_elig && wr1_elig) begin
        wr0_gnt = last_wr;
        wr1_gnt = !last_wr;
      end else begin
        wr0_gnt = wr0_elig;
        wr1_gnt = wr1_elig;
      end
    end

    if (vid_gnt) begin
      MEM_ADDR = vid_addr;
    end else if (clr_gnt) begin
      MEM_ADDR = clr_cnt;
      MEM_WE   = 1'b1;
    end else if (wr0_gnt) begin
      MEM_ADDR     = wr0_addr;
      MEM_WE       = wr0_inr;
      MEM_WDATA    = WR0_DATA;
      last_wr_next = 1'b0;
    end else if (wr1_gnt) begin
      MEM_ADDR     = wr1_addr;
      MEM_WE       = wr1_inr;
      MEM_WDATA    = WR1_DATA;
      last_wr_next = 1'b1;
    end
  end

  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    case (state)
      S_IDLE: begin
        if (CLR_START) begin
          state_next   = S_CLEAR;
          clr_cnt_next = '0;
        end
      end
      S_CLEAR: begin
        if (clr_gnt) begin
          if (clr_cnt == LAST_ADDR) begin
            state_next   = S_IDLE;
            clr_cnt_next = '0;
          end else begin
            clr_cnt_next = clr_cnt + 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Reset) begin
      state     <= S_IDLE;
      clr_cnt   <= '0;
      last_wr   <= 1'b1;
      WR0_ACK   <= 1'b0;
      WR1_ACK   <= 1'b0;
      WR_ERR    <= 1'b0;
      vid_pend  <= 1'b0;
      vid_oor   <= 1'b0;
      VID_VALID <= 1'b0;
      VID_DATA  <= CELL_WATER;
    end else begin
      state     <= state_next;
      clr_cnt   <= clr_cnt_next;
      last_wr   <= last_wr_next;
      WR0_ACK   <= wr0_gnt;
      WR1_ACK   <= wr1_gnt;
      WR_ERR    <= (wr0_gnt && !wr0_inr) || (wr1_gnt && !wr1_inr);
      vid_pend  <= vid_gnt;
      vid_oor   <= !vid_inr;
      VID_VALID <= vid_pend;
      if (vid_pend) begin
        VID_DATA <= vid_oor ? CELL_WATER : MEM_RDATA;
      end
    end
  end

  assign CLR_BUSY = (state == S_CLEAR);

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Self-checking bench for board_mem_arbiter with a behavioural synchronous RAM.
module tb_board_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vid_req, vid_board;
  logic [3:0] vid_row, vid_col;
  logic [1:0] vid_data;
  logic       vid_valid;
  logic       wr0_req, wr0_board, wr0_ack;
  logic [3:0] wr0_row, wr0_col;
  logic [1:0] wr0_data;
  logic       wr1_req, wr1_board, wr1_ack;
  logic [3:0] wr1_row, wr1_col;
  logic [1:0] wr1_data;
  logic       wr_err, clr_start, clr_busy;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  board_mem_arbiter #(.BOARD_DIM(10), .ADDR_W(8)) dut (
    .CLOCK_50(clk), .Reset(rst_n),
    .VID_REQ(vid_req), .VID_BOARD(vid_board), .VID_ROW(vid_row), .VID_COL(vid_col),
    .VID_DATA(vid_data), .VID_VALID(vid_valid),
    .WR0_REQ(wr0_req), .WR0_BOARD(wr0_board), .WR0_ROW(wr0_row), .WR0_COL(wr0_col),
    .WR0_DATA(wr0_data), .WR0_ACK(wr0_ack),
    .WR1_REQ(wr1_req), .WR1_BOARD(wr1_board), .WR1_ROW(wr1_row), .WR1_COL(wr1_col),
    .WR1_DATA(wr1_data), .WR1_ACK(wr1_ack),
    .WR_ERR(wr_err), .CLR_START(clr_start), .CLR_BUSY(clr_busy),
    .MEM_ADDR(mem_addr), .MEM_WE(mem_we), .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata)
  );

  typedef struct {
    logic [1:0] data;
    int         due;
  } vexp_t;

  typedef struct {
    logic       b;
    logic [3:0] r;
    logic [3:0] c;
    logic [1:0] exp;
  } vvec_t;

  logic [1:0] mem [256];
  vexp_t      vq[$];
  vvec_t      vtab[10];
  int         cyc = 0;
  int         nvec = 0;
  int         nfail = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int cell_addr(input int b, input int r, input int c);
    return (b * 100 + r * 10 + c) % 256;
  endfunction

  task automatic preload();
    for (int i = 0; i < 256; i++) mem[i] = 2'((i % 3) + 1);
    mem[123] = 2'd3;
  endtask

  // One clock: RAM model captures the port mid-cycle, then video output is scored.
  task automatic tick();
    logic [7:0] a;
    logic       we;
    logic [1:0] wd;
    vexp_t      e;
    @(negedge clk);
    a  = mem_addr;
    we = mem_we;
    wd = mem_wdata;
    @(posedge clk);
    #1;
    cyc++;
    mem_rdata = mem[a];
    if (we) mem[a] = wd;
    if (vid_valid) begin
      if (vq.size() == 0) begin
        chk("vid_spurious_valid", int'(vid_valid), 0);
      end else begin
        e = vq.pop_front();
        chk("vid_data", int'(vid_data), int'(e.data));
        chk("vid_latency", cyc, e.due);
      end
    end else if (vq.size() != 0 && vq[0].due <= cyc) begin
      chk("vid_valid_missing", int'(vid_valid), 1);
      void'(vq.pop_front());
    end
  endtask

  task automatic vid_drive(input logic b, input logic [3:0] r, input logic [3:0] c,
                           input logic [1:0] exp);
    vid_req   = 1'b1;
    vid_board = b;
    vid_row   = r;
    vid_col   = c;
    vq.push_back('{exp, cyc + 2});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    int n;
    int nz;
    logic is_vid;

    vtab[0] = '{1'b1, 4'd2,  4'd3,  2'd3};
    vtab[1] = '{1'b1, 4'd2,  4'd3,  2'd3};
    vtab[2] = '{1'b0, 4'd0,  4'd0,  2'd1};
    vtab[3] = '{1'b0, 4'd0,  4'd1,  2'd2};
    vtab[4] = '{1'b0, 4'd4,  4'd7,  2'd3};
    vtab[5] = '{1'b1, 4'd9,  4'd9,  2'd2};
    vtab[6] = '{1'b1, 4'd0,  4'd0,  2'd2};
    vtab[7] = '{1'b0, 4'd12, 4'd0,  2'd0};
    vtab[8] = '{1'b0, 4'd5,  4'd10, 2'd0};
    vtab[9] = '{1'b0, 4'd9,  4'd9,  2'd1};

    rst_n = 1'b0;
    vid_req = 1'b0; vid_board = 1'b0; vid_row = '0; vid_col = '0;
    wr0_req = 1'b0; wr0_board = 1'b0; wr0_row = '0; wr0_col = '0; wr0_data = '0;
    wr1_req = 1'b0; wr1_board = 1'b0; wr1_row = '0; wr1_col = '0; wr1_data = '0;
    clr_start = 1'b0;
    mem_rdata = '0;
    preload();

    // Reset state
    repeat (3) tick();
    chk("rst_vid_data", int'(vid_data), 0);
    chk("rst_vid_valid", int'(vid_valid), 0);
    chk("rst_wr0_ack", int'(wr0_ack), 0);
    chk("rst_wr1_ack", int'(wr1_ack), 0);
    chk("rst_wr_err", int'(wr_err), 0);
    chk("rst_clr_busy", int'(clr_busy), 0);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_mem_wdata", int'(mem_wdata), 0);
    rst_n = 1'b1;
    tick();

    // Table-driven back-to-back video reads
    for (int i = 0; i < 10; i++) begin
      vid_drive(vtab[i].b, vtab[i].r, vtab[i].c, vtab[i].exp);
      #1;
      chk("vid_addr", int'(mem_addr), cell_addr(int'(vtab[i].b), int'(vtab[i].r), int'(vtab[i].c)));
      chk("vid_we", int'(mem_we), 0);
      tick();
    end
    vid_req = 1'b0;
    repeat (3) tick();
    chk("vid_queue_drained", vq.size(), 0);

    // Round-robin writers: held requests alternate 0,1,0,1
    wr0_board = 1'b0; wr0_row = 4'd1; wr0_col = 4'd1; wr0_data = 2'd1;
    wr1_board = 1'b1; wr1_row = 4'd1; wr1_col = 4'd1; wr1_data = 2'd2;
    wr0_req = 1'b1; wr1_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk("rr_mem_we", int'(mem_we), 1);
      chk("rr_mem_addr", int'(mem_addr), (g % 2 == 0) ? 11 : 111);
      chk("rr_mem_wdata", int'(mem_wdata), (g % 2 == 0) ? 1 : 2);
      tick();
      chk("rr_ack0", int'(wr0_ack), (g % 2 == 0) ? 1 : 0);
      chk("rr_ack1", int'(wr1_ack), (g % 2 == 0) ? 0 : 1);
      chk("rr_err", int'(wr_err), 0);
    end
    wr0_req = 1'b0; wr1_req = 1'b0;
    tick();
    chk("rr_idle_ack0", int'(wr0_ack), 0);
    chk("rr_idle_ack1", int'(wr1_ack), 0);
    wr0_data = 2'd3; wr1_data = 2'd0;
    wr0_req = 1'b1; wr1_req = 1'b1;
    #1;
    chk("rr_fresh_first", int'(mem_addr), 11);
    tick();
    wr0_req = 1'b0; wr1_req = 1'b0;
    chk("rr_fresh_ack0", int'(wr0_ack), 1);
    tick();
    wr0_req = 1'b1; wr1_req = 1'b1;
    #1;
    chk("rr_fresh_second", int'(mem_addr), 111);
    tick();
    wr0_req = 1'b0; wr1_req = 1'b0;
    chk("rr_fresh_ack1", int'(wr1_ack), 1);
    tick();
    chk("rr_ram_11", int'(mem[11]), 3);
    chk("rr_ram_111", int'(mem[111]), 0);

    // Video held continuously starves WR0
    wr0_board = 1'b0; wr0_row = 4'd2; wr0_col = 4'd2; wr0_data = 2'd3;
    wr0_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vid_drive(1'b0, 4'd0, 4'd0, 2'd1);
      #1;
      chk("starve_mem_we", int'(mem_we), 0);
      chk("starve_mem_addr", int'(mem_addr), 0);
      tick();
      chk("starve_ack0", int'(wr0_ack), 0);
    end
    vid_req = 1'b0;
    #1;
    chk("starve_release_we", int'(mem_we), 1);
    chk("starve_release_addr", int'(mem_addr), 22);
    tick();
    chk("starve_release_ack0", int'(wr0_ack), 1);
    wr0_req = 1'b0;
    tick();
    chk("starve_ack0_pulse", int'(wr0_ack), 0);
    chk("starve_ram_22", int'(mem[22]), 3);

    // Out-of-range write is acknowledged with WR_ERR and never written
    wr1_board = 1'b0; wr1_row = 4'd10; wr1_col = 4'd3; wr1_data = 2'd1;
    wr1_req = 1'b1;
    #1;
    chk("oor_mem_we", int'(mem_we), 0);
    tick();
    chk("oor_ack1", int'(wr1_ack), 1);
    chk("oor_err", int'(wr_err), 1);
    wr1_req = 1'b0;
    tick();
    chk("oor_ack1_pulse", int'(wr1_ack), 0);
    chk("oor_err_pulse", int'(wr_err), 0);
    chk("oor_ram_103", int'(mem[103]), 2);
    vid_drive(1'b0, 4'd12, 4'd0, 2'd0);
    tick();
    vid_req = 1'b0;
    repeat (3) tick();
    chk("oor_vid_drained", vq.size(), 0);

    // Clear sweep with no traffic
    clr_start = 1'b1;
    #1;
    chk("clr_busy_start_cycle", int'(clr_busy), 0);
    tick();
    clr_start = 1'b0;
    k = 0;
    for (int i = 0; i < 400 && clr_busy; i++) begin
      chk("clr_addr", int'(mem_addr), k);
      chk("clr_we", int'(mem_we), 1);
      chk("clr_wdata", int'(mem_wdata), 0);
      k++;
      tick();
    end
    chk("clr_busy_cycles", k, 200);
    chk("clr_busy_end", int'(clr_busy), 0);
    nz = 0;
    for (int i = 0; i < 200; i++) if (mem[i] != 2'd0) nz++;
    chk("clr_ram_zero", nz, 0);
    chk("clr_ram_200_kept", int'(mem[200]), 3);

    // Clear with 5 video cycles interleaved and a writer waiting
    preload();
    clr_start = 1'b1;
    wr0_board = 1'b0; wr0_row = 4'd3; wr0_col = 4'd3; wr0_data = 2'd2;
    wr0_req = 1'b1;
    #1;
    chk("clr2_start_wr_addr", int'(mem_addr), 33);
    chk("clr2_start_wr_we", int'(mem_we), 1);
    tick();
    clr_start = 1'b0;
    wr0_col = 4'd4; wr0_data = 2'd3;
    k = 0;
    n = 0;
    while (n < 400 && clr_busy) begin
      chk("clr2_ack0", int'(wr0_ack), (n == 0) ? 1 : 0);
      is_vid = (n == 10 || n == 11 || n == 50 || n == 100 || n == 150);
      if (is_vid) begin
        vid_drive(1'b1, 4'd9, 4'd9, 2'd2);
        #1;
        chk("clr2_vid_we", int'(mem_we), 0);
        chk("clr2_vid_addr", int'(mem_addr), 199);
      end else begin
        vid_req = 1'b0;
        #1;
        chk("clr2_addr", int'(mem_addr), k);
        chk("clr2_we", int'(mem_we), 1);
        k++;
      end
      n++;
      tick();
    end
    vid_req = 1'b0;
    chk("clr2_busy_cycles", n, 205);
    chk("clr2_writes", k, 200);
    #1;
    chk("clr2_wr_after_addr", int'(mem_addr), 34);
    chk("clr2_wr_after_we", int'(mem_we), 1);
    tick();
    chk("clr2_wr_after_ack0", int'(wr0_ack), 1);
    wr0_req = 1'b0;
    tick();
    chk("clr2_ram_34", int'(mem[34]), 3);
    chk("clr2_vid_drained", vq.size(), 0);

    // Reset mid-clear at address 50
    preload();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 300 && clr_busy; i++) begin
      if (mem_addr == 8'd50) break;
      tick();
    end
    chk("abort_reach_50", int'(mem_addr), 50);
    rst_n = 1'b0;
    tick();
    chk("abort_busy_low", int'(clr_busy), 0);
    rst_n = 1'b1;
    tick();
    chk("abort_busy_stays_low", int'(clr_busy), 0);
    chk("abort_ram_49", int'(mem[49]), 0);
    chk("abort_ram_50", int'(mem[50]), 3);
    chk("abort_ram_199", int'(mem[199]), 2);
    wr1_board = 1'b1; wr1_row = 4'd0; wr1_col = 4'd5; wr1_data = 2'd3;
    wr1_req = 1'b1;
    #1;
    chk("abort_wr_we", int'(mem_we), 1);
    chk("abort_wr_addr", int'(mem_addr), 105);
    tick();
    chk("abort_wr_ack1", int'(wr1_ack), 1);
    wr1_req = 1'b0;
    tick();
    chk("abort_ram_105", int'(mem[105]), 3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/board_mem_arbiter.md
# board_mem_arbiter

Scheduler for the single-port board-state RAM that feeds the VGA pixel path of the Batalha Naval display. It shares one RAM port between three users: the pixel generator's cell reads (absolute priority, fixed latency), two game-logic writers (player 0 and player 1 shot results, round-robin), and an internal clear sweep for a new game. It sits between the sync/pixel generation chain and an external synchronous `board_ram`, all in the `CLOCK_50` domain.

## Interface
- `BOARD_DIM`, default 10: cells per row and column.
- `ADDR_W`, default 8: RAM address width; must hold 2·BOARD_DIM² − 1.

Ports:
- `CLOCK_50`  in  1: system clock.
- `Reset`  in  1: reset, synchronous, active-low.
- `VID_REQ`  in  1: pixel path requests a cell read this cycle.
- `VID_BOARD`  in  1: board select, 0 or 1.
- `VID_ROW`, `VID_COL`  in  4 each: cell coordinates.
- `VID_DATA`  out  2: cell state.
- `VID_VALID`  out  1: `VID_DATA` valid.
- `WRn_REQ`  in  1 (n = 0, 1): write request; held until `WRn_ACK`.
- `WRn_BOARD`  in  1, `WRn_ROW`/`WRn_COL`  in  4, `WRn_DATA`  in  2: write target and value.
- `WRn_ACK`  out  1: one-cycle acknowledge.
- `WR_ERR`  out  1: one-cycle pulse when an out-of-range write is acknowledged.
- `CLR_START`  in  1: start the clear sweep.
- `CLR_BUSY`  out  1: clear in progress.
- `MEM_ADDR`  out  ADDR_W, `MEM_WE`  out  1, `MEM_WDATA`  out  2: RAM port.
- `MEM_RDATA`  in  2: RAM read data, one cycle after the address.

## Operation
- Address formula: BOARD·100 + ROW·10 + COL.
  - ROW·10 is computed as (ROW<<3)+(ROW<<1), unsigned and zero-extended to ADDR_W.
  - A coordinate is in range iff ROW<BOARD_DIM and COL<BOARD_DIM.
- Per-cycle grant priority: video > clear > writers.
- **Video grant:** drives `MEM_ADDR` and `MEM_WE`=0. An out-of-range read still returns a result, forced to 0 (water).
- **Writer arbitration:**
  - Eligible writer: REQ=1 and its ACK not high this cycle. This prevents a double grant while REQ is still held.
  - If both are eligible, grant the writer not granted last. The last-granted pointer resets to 1, so WR0 wins first.
  - Granted in-range write: `MEM_WE`=1 with `MEM_WDATA`.
  - Granted out-of-range write: `MEM_WE`=0; the write is still acknowledged, with `WR_ERR`.
- **FSM states:**
  - S_IDLE: video and writers arbitrate. If `CLR_START`=1, writers are still arbitrated in that cycle, then go to S_CLEAR with counter=0.
  - S_CLEAR: on each cycle without a video request, write 0 to address counter and increment. Writers receive no ACK. After writing address 2·BOARD_DIM²−1, return to S_IDLE. `CLR_START` is ignored in this state.
- `CLR_BUSY` = (state == S_CLEAR), registered.
- Video stalls clearing but is never stalled itself.
- Reset mid-clear aborts the sweep; RAM is left partially cleared.

## Timing
- Reset values: `VID_DATA`=0, `VID_VALID`=0, `WRn_ACK`=0, `WR_ERR`=0, `CLR_BUSY`=0, `MEM_WE`=0, `MEM_ADDR`=0, `MEM_WDATA`=0, state S_IDLE, counter 0.
- `MEM_ADDR`, `MEM_WE` and `MEM_WDATA` are combinational from the current cycle's grant. All other outputs are registered.
- **Video read latency is 2.**
  - A `VID_REQ` at cycle t drives the address at t.
  - RAM data arrives at t+1.
  - `VID_DATA`/`VID_VALID` are registered at t+2.
  - Reads are fully pipelined, one per cycle.
- `WRn_ACK` and `WR_ERR` are high at t+1 for a write granted at t.
- Clear with no video traffic:
  - `CLR_START` at t: writes at t+1…t+200.
  - `CLR_BUSY` is high t+1…t+200 and low at t+201.
  - Each video cycle extends the clear by 1.

## Structure
- Package `board_pkg`:
  - Constants: CELL_WATER=0, CELL_SHIP=1, CELL_HIT=2, CELL_MISS=3; BOARD_DIM, CELLS_PER_BOARD=100, MEM_DEPTH=200, ADDR_W.
  - FSM state typedef (S_IDLE, S_CLEAR).
- Sub-module `board_addr_calc`: combinational (board, row, col) → (addr, in_range). Instantiated three times: video, WR0, WR1.
- The RAM (`board_ram`) is external and not part of this block.

## Test plan
- Post-reset, RAM preloaded with 3 at addr 123; video reads (1,2,3) → `VID_DATA`=3, `VID_VALID` exactly 2 cycles later; back-to-back reads return in order.
- WR0 and WR1 request the same cycle, video idle → WR0 written first (ACK0 next cycle), WR1 the following cycle; repeat → alternation holds.
- `VID_REQ` held continuously while WR0 requests → no `MEM_WE`, no ACK; ACK0 arrives 1 cycle after `VID_REQ` drops.
- WR1 write with ROW=10 → `WR1_ACK` and `WR_ERR` pulse together, `MEM_WE` never asserted; a video read of (0,12,0) → `VID_DATA`=0.
- `CLR_START` with no traffic → 200 writes of 0 to addresses 0…199, `CLR_BUSY` high for exactly 200 cycles; with 5 interleaved video cycles → 205.
- `Reset` asserted at clear address 50 → `CLR_BUSY`=0 next cycle, addresses ≥50 keep old data, writers served normally afterward.
